// File: rtl/hack_arb_pkg.sv
// Shared types and constants for the Hack memory arbiter.
package hack_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      GAP
   } arb_state_t;

   localparam int unsigned DEFAULT_MAX_BEATS = 4;

   // Default requester assignment.
   localparam int unsigned REQ_FETCH = 0;
   localparam int unsigned REQ_DATA  = 1;
   localparam int unsigned REQ_LOAD  = 2;

endpackage

// File: rtl/hack_mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester above last_winner, with wrap.
module rr_pick #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned SEL_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last_winner,
   output logic [SEL_W-1:0]   winner,
   output logic               valid
);

   // Scan offsets from farthest to nearest so the nearest pending requester wins.
   always_comb begin
      logic [SEL_W-1:0] idx;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int unsigned off = NUM_REQ; off >= 1; off--) begin
         idx = SEL_W'((32'(last_winner) + off) % NUM_REQ);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Round-robin arbiter for the single-port Hack memory with multi-beat
// ownership, a beat hold limit and a one-cycle break-before-make gap.
module hack_mem_arbiter
   import hack_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = 3,
   parameter  int unsigned MAX_BEATS = DEFAULT_MAX_BEATS,
   localparam int unsigned SEL_W     = $clog2(NUM_REQ)
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic [NUM_REQ-1:0] req_in,
   input  logic               done_in,
   output logic [NUM_REQ-1:0] gnt_out,
   output logic [SEL_W-1:0]   sel_out,
   output logic               busy_out,
   output logic [7:0]         beat_cnt_out
);

   arb_state_t         state;
   logic [SEL_W-1:0]   last_winner;
   logic [SEL_W-1:0]   pick_w;
   logic               pick_valid;
   logic [NUM_REQ-1:0] pick_onehot;
   logic               owner_req;
   logic               last_beat;
   logic               release_now;
   logic [7:0]         beat_next;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .SEL_W   (SEL_W)
   ) u_pick (
      .req         (req_in),
      .last_winner (last_winner),
      .winner      (pick_w),
      .valid       (pick_valid)
   );

   // Decode of the current owner's request and the release/beat conditions.
   always_comb begin
      pick_onehot = NUM_REQ'(1) << pick_w;
      owner_req   = req_in[sel_out];
      last_beat   = (beat_cnt_out == 8'(MAX_BEATS - 1));
      // Abandon (with or without a final beat) or hold limit reached.
      release_now = !owner_req || (done_in && last_beat);
      beat_next   = beat_cnt_out;
      if (done_in && (beat_cnt_out < 8'(MAX_BEATS))) begin
         beat_next = beat_cnt_out + 8'd1;
      end
   end

   // Arbitration FSM with registered grant, select, busy and beat count.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= IDLE;
         last_winner  <= SEL_W'(NUM_REQ - 1);
         gnt_out      <= '0;
         sel_out      <= '0;
         busy_out     <= 1'b0;
         beat_cnt_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt_out      <= pick_onehot;
                  sel_out      <= pick_w;
                  busy_out     <= 1'b1;
                  beat_cnt_out <= '0;
                  last_winner  <= pick_w;
                  state        <= OWN;
               end
            end
            OWN: begin
               beat_cnt_out <= beat_next;
               if (release_now) begin
                  gnt_out  <= '0;
                  busy_out <= 1'b0;
                  state    <= GAP;
               end
            end
            GAP: begin
               beat_cnt_out <= '0;
               state        <= IDLE;
            end
            default: begin
               gnt_out  <= '0;
               busy_out <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
